// File: rtl/dmem_ctrl_pkg.sv
// ============================================================================
// dmem_ctrl_pkg : shared funct3 codes and controller state encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] S_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_fmt.sv
// ============================================================================
// dmem_lane_fmt : RV32 byte-lane steering, load extension and access checking
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_lane_fmt
  import dmem_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_illegal;
  logic        w_misaligned;

  always_comb begin
    w_shift      = rdata_raw >> {addr_lo, 3'b000};
    w_byte       = w_shift[7:0];
    w_half       = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    byte_en      = 4'b0000;
    wdata_lane   = wdata;
    rdata_ext    = 32'h0;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{w_byte[7]}}, w_byte};
      end
      F3_H: begin
        w_misaligned = addr_lo[0];
        byte_en      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane   = {2{wdata[15:0]}};
        rdata_ext    = {{16{w_half[15]}}, w_half};
      end
      F3_W: begin
        w_misaligned = |addr_lo;
        byte_en      = 4'b1111;
        rdata_ext    = rdata_raw;
      end
      F3_BU: begin
        w_illegal = we;
        rdata_ext = {24'h0, w_byte};
      end
      F3_HU: begin
        w_illegal    = we;
        w_misaligned = addr_lo[0];
        rdata_ext    = {16'h0, w_half};
      end
      default: w_illegal = 1'b1;
    endcase

    err = w_illegal | w_misaligned;
    // Lanes are only enabled for a legal store; stores and errors return zero data.
    if (err || !we) byte_en = 4'b0000;
    if (err || we) rdata_ext = 32'h0;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : valid/ready data memory with RV32 sub-word access and wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter  int DEPTH       = 64,
  parameter  int WAIT_STATES = 0,
  localparam int ADDR_W      = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_err;
  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_wr;
  logic               w_cur_we;
  logic [2:0]         w_cur_funct3;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic [31:0]        w_cur_wdata;
  logic [IDX_W-1:0]   w_idx;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_wdata_lane;
  logic [31:0]        w_rdata_ext;
  logic               w_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (r_cnt == WAIT_LAST) w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

  assign w_accept     = req_valid & req_ready;
  assign w_enter_resp = (w_state_nxt == S_RESP) && (r_state != S_RESP);
  // An idle-to-RESP jump (no wait states) must use the live request, not the capture registers.
  assign w_cur_we     = (r_state == S_IDLE) ? req_we     : r_we;
  assign w_cur_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
  assign w_cur_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
  assign w_cur_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;
  assign w_idx        = w_cur_addr[ADDR_W-1:2];
  assign w_wr         = w_enter_resp & rst_n;

  dmem_lane_fmt u_lane_fmt (
    .we         (w_cur_we),
    .funct3     (w_cur_funct3),
    .addr_lo    (w_cur_addr[1:0]),
    .wdata      (w_cur_wdata),
    .rdata_raw  (r_mem[w_idx]),
    .byte_en    (w_byte_en),
    .wdata_lane (w_wdata_lane),
    .rdata_ext  (w_rdata_ext),
    .err        (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_cnt    <= 4'd0;
      r_rdata  <= 32'h0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
      end
      if (r_state == S_WAIT) r_cnt <= r_cnt + 4'd1;
      else                   r_cnt <= 4'd0;
      if (w_enter_resp) begin
        r_rdata <= w_rdata_ext;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr && w_byte_en[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : directed bench for dmem_ctrl with a byte-level memory model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        req_valid  = 1'b0;
  logic        req_we     = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [7:0]  req_addr   = 8'h00;
  logic [31:0] req_wdata  = 32'h0;
  logic        rsp_ready  = 1'b0;
  int          sel        = 0;

  logic        rdy0, vld0, err0, rdy3, vld3, err3;
  logic [31:0] rd0, rd3;

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  mdl [0:1][0:255];
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err   = 1'b0;
  bit          exp_busy  = 1'b0;

  always #5 clk = ~clk;

  // dut0: 64 words, no wait states; dut3: 16 words, three wait states
  dmem_ctrl #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && (sel == 0)), .req_ready(rdy0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld0), .rsp_ready(rsp_ready && (sel == 0)), .rsp_rdata(rd0), .rsp_err(err0)
  );

  dmem_ctrl #(.DEPTH(16), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && (sel == 3)), .req_ready(rdy3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr[5:0]), .req_wdata(req_wdata),
    .rsp_valid(vld3), .rsp_ready(rsp_ready && (sel == 3)), .rsp_rdata(rd3), .rsp_err(err3)
  );

  wire        rdy = (sel == 3) ? rdy3 : rdy0;
  wire        vld = (sel == 3) ? vld3 : vld0;
  wire        er  = (sel == 3) ? err3 : err0;
  wire [31:0] rd  = (sel == 3) ? rd3  : rd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-addressed reference: size from funct3, word index wraps modulo depth.
  function automatic void model(input int s, input bit we, input logic [2:0] f3,
                                input logic [7:0] a, input logic [31:0] wd,
                                output logic [31:0] rdv, output logic erv);
    int size, depth, base, off, k;
    bit legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
    erv   = !legal || ((int'(a) % size) != 0);
    depth = (s == 3) ? 16 : 64;
    k     = (s == 3) ? 1 : 0;
    base  = ((int'(a) / 4) % depth) * 4;
    off   = int'(a) % 4;
    rdv   = 32'h0;
    if (erv) return;
    for (int i = 0; i < size; i++) begin
      if (we) mdl[k][base+off+i] = wd[8*i +: 8];
      else    rdv = rdv | (32'(mdl[k][base+off+i]) << (8*i));
    end
    if (!we && !f3[2] && size < 4 && rdv[8*size-1]) rdv = rdv | ~((32'd1 << (8*size)) - 32'd1);
  endfunction

  always @(negedge clk) begin
    if (exp_busy && vld) begin
      chk("rsp_rdata", rd, exp_rdata);
      chk("rsp_err", {31'h0, er}, {31'h0, exp_err});
    end
  end

  // One full transaction; starts and ends on a falling edge with the target idle.
  task automatic xact(input int s, input bit we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, input int hold, input bit pin,
                      input logic [31:0] lit, input logic lit_err);
    logic [31:0] mrd;
    logic        mer;
    int          n, w;
    w = (s == 3) ? 3 : 0;
    sel = s; req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rsp_ready = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); n++; end
    chk("accept_wait", n, 0);
    @(posedge clk); #1;
    model(s, we, f3, a, wd, mrd, mer);
    exp_rdata = mrd; exp_err = mer; exp_busy = 1'b1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111; req_addr = ~a; req_wdata = ~wd;
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      chk("rsp_valid_timing", {31'h0, vld}, {31'h0, k == w});
      chk("req_ready_busy", {31'h0, rdy}, 32'h0);
    end
    if (pin) begin
      chk("pinned_rdata", rd, lit);
      chk("pinned_err", {31'h0, er}, {31'h0, lit_err});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("held_valid", {31'h0, vld}, 32'h1);
      chk("held_ready", {31'h0, rdy}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; exp_busy = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'h0, vld}, 32'h0);
    chk("post_ready", {31'h0, rdy}, 32'h1);
  endtask

  initial begin
    logic [31:0] mrd;
    logic        mer;

    // Reset with a request already presented
    #1 rst_n = 1'b0;
    sel = 0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 8'h08; req_wdata = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    chk("reset_req_ready0", {31'h0, rdy0}, 32'h1);
    chk("reset_rsp_valid0", {31'h0, vld0}, 32'h0);
    chk("reset_rsp_rdata0", rd0, 32'h0);
    chk("reset_rsp_err0", {31'h0, err0}, 32'h0);
    chk("reset_req_ready3", {31'h0, rdy3}, 32'h1);
    chk("reset_rsp_valid3", {31'h0, vld3}, 32'h0);
    rst_n = 1'b1;

    xact(0, 1, F3_W, 8'h08, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0);
    xact(0, 0, F3_W, 8'h08, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0);

    // Sub-word access
    xact(0, 1, F3_B,  8'h09, 32'h00000080, 0, 0, 32'h0, 1'b0);
    xact(0, 0, F3_B,  8'h09, 32'h0, 0, 1, 32'hFFFFFF80, 1'b0);
    xact(0, 0, F3_BU, 8'h09, 32'h0, 0, 1, 32'h00000080, 1'b0);
    xact(0, 0, F3_W,  8'h08, 32'h0, 0, 1, 32'hDEAD80EF, 1'b0);
    xact(0, 0, F3_H,  8'h0A, 32'h0, 0, 1, 32'hFFFFDEAD, 1'b0);
    xact(0, 0, F3_HU, 8'h0A, 32'h0, 0, 1, 32'h0000DEAD, 1'b0);
    xact(0, 1, F3_H,  8'h0A, 32'hFFFF7E57, 1, 0, 32'h0, 1'b0);
    xact(0, 0, F3_W,  8'h08, 32'h0, 0, 1, 32'h7E5780EF, 1'b0);

    // Misaligned and illegal accesses leave memory untouched
    xact(0, 1, F3_W,   8'h04, 32'h11223344, 0, 0, 32'h0, 1'b0);
    xact(0, 1, F3_W,   8'h00, 32'hA5A5A5A5, 0, 0, 32'h0, 1'b0);
    xact(0, 0, F3_W,   8'h06, 32'h0, 0, 1, 32'h0, 1'b1);
    xact(0, 1, F3_H,   8'h03, 32'h0000BEEF, 0, 1, 32'h0, 1'b1);
    xact(0, 0, 3'b011, 8'h00, 32'h0, 0, 1, 32'h0, 1'b1);
    xact(0, 1, F3_BU,  8'h04, 32'h000000FF, 0, 1, 32'h0, 1'b1);
    xact(0, 0, F3_W,   8'h04, 32'h0, 0, 1, 32'h11223344, 1'b0);
    xact(0, 0, F3_W,   8'h00, 32'h0, 0, 1, 32'hA5A5A5A5, 1'b0);

    // A store presented while in reset must not be written
    rst_n = 1'b0; sel = 0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 8'h04; req_wdata = 32'hBAD0BAD0;
    repeat (2) @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    xact(0, 0, F3_W, 8'h04, 32'h0, 0, 1, 32'h11223344, 1'b0);

    // Wait states with a stalled consumer, back-to-back
    xact(3, 1, F3_W, 8'h08, 32'hCAFEF00D, 5, 0, 32'h0, 1'b0);
    xact(3, 0, F3_W, 8'h08, 32'h0, 5, 1, 32'hCAFEF00D, 1'b0);
    xact(3, 0, F3_H, 8'h0A, 32'h0, 0, 1, 32'hFFFFCAFE, 1'b0);

    // Reset during WAIT aborts the pending store
    xact(3, 1, F3_W, 8'h10, 32'h0BADF00D, 0, 0, 32'h0, 1'b0);
    sel = 3; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 8'h10; req_wdata = 32'h12345678;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait_no_valid", {31'h0, vld3}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wait_valid", {31'h0, vld3}, 32'h0);
    chk("abort_wait_ready", {31'h0, rdy3}, 32'h1);
    rst_n = 1'b1;
    xact(3, 0, F3_W, 8'h10, 32'h0, 0, 1, 32'h0BADF00D, 1'b0);

    // Reset during RESP keeps the committed store
    sel = 3; req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 8'h14; req_wdata = 32'h5555AAAA;
    @(posedge clk); #1 req_valid = 1'b0;
    model(3, 1, F3_W, 8'h14, 32'h5555AAAA, mrd, mer);
    repeat (4) @(negedge clk);
    chk("resp_reached", {31'h0, vld3}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_resp_valid", {31'h0, vld3}, 32'h0);
    rst_n = 1'b1;
    xact(3, 0, F3_W, 8'h14, 32'h0, 0, 1, 32'h5555AAAA, 1'b0);

    // Index wraps at DEPTH=16
    xact(3, 1, F3_W, 8'h00, 32'h77665544, 0, 0, 32'h0, 1'b0);
    xact(3, 0, F3_W, 8'h40, 32'h0, 0, 1, 32'h77665544, 1'b0);
    xact(3, 0, F3_B, 8'h43, 32'h0, 0, 1, 32'h00000077, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
